encoder_rr_arbiter: RTL and testbench
=====================================

# encoder_rr_arbiter

Registered, parametrised M-to-N request encoder with a selectable fixed-priority or round-robin mode and a valid/ready output handshake. It samples a request vector, picks one winner, and holds the winner's binary index and one-hot grant stable until the consumer accepts it. It sits between multiple requesters (interrupt sources, bus masters, LSU/IFU ports) and a single downstream consumer in the NPC core. It succeeds the purely combinational priority encoders: it adds registered output, backpressure and fairness.

## Interface
- M, default 8: number of request lines; M >= 2.
- N, default 3: output index width; 2^N >= M is required, and an elaboration-time check fails otherwise.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbitration enable; a new winner is picked only when en=1.
- mode  input  1  0 = fixed priority, where the highest index wins; 1 = round-robin.
- req  input  M  request vector; bit i set means requester i is pending.
- out_valid  output  1  the registered grant is valid.
- out_ready  input  1  the consumer accepts the grant this cycle.
- y  output  N  binary index of the winner.
- grant  output  M  one-hot of the winner; equals (1 << y) whenever out_valid=1.

## Operation
- There are two states, IDLE and HOLD. Reset puts the block in IDLE with out_valid=0, y=0, grant=0 and ptr=M-1.
- **Arbitration event:** occurs when en=1 and req!=0, and either the block is in IDLE or the block is in HOLD with out_valid && out_ready (the handshake completes).
  - On the event, the winner w is registered into y and grant.
  - out_valid is set to 1 and the state becomes HOLD.
- **IDLE:** if there is no arbitration event, the block stays in IDLE with outputs unchanged and out_valid=0.
- **HOLD:** while out_ready=0, y, grant and out_valid are frozen regardless of req, en or mode.
- **Handshake completion:** the pointer updates on out_valid && out_ready.
  - If an arbitration event also occurs in that same cycle, the block re-arbitrates (back-to-back) and stays in HOLD.
  - Otherwise it goes to IDLE, out_valid=0, and y and grant are cleared to 0.
- **Fixed mode (mode=0):** w is the highest set index of req. The pointer is ignored but still updated.
- **Round-robin mode (mode=1):**
  - Search starts at ptr and moves downward: ptr, ptr-1, …, 0, M-1, …, ptr+1. The first set bit is w.
  - On handshake completion, ptr <= (y==0) ? M-1 : y-1.
  - The most recently served requester therefore gets the lowest priority next time.
- **ptr** is a $clog2(M)-bit register with wrap at M, not at 2^N. Values >= M are never produced.
- **Requester obligations:** the block does not clear req bits. A requester deasserts its own bit after seeing its grant accepted.
- **mode and en:** both are sampled only at arbitration events. Changing either during HOLD has no effect on the held grant.
- **Reset mid-operation:** rst=1 overrides everything, including a handshake completing in the same cycle. The pending grant is dropped.

## Timing
- Latency is 1 cycle: an arbitration event at edge k makes out_valid=1 and y valid after edge k.
- Throughput is one grant per cycle while out_ready=1 and req!=0.
- out_ready is permitted to be high while out_valid=0; it has no effect in that case.
- There is no combinational path from req, en, mode or out_ready to any output. All outputs come from registers.

## Structure
- The shared package encoder_pkg holds:
  - the MODE_FIXED=1'b0 and MODE_RR=1'b1 constants;
  - the state enum {IDLE, HOLD}.
- The sub-module encoder_rr_search is a combinational circular priority search.
  - Inputs: req[M-1:0] and start[$clog2(M)-1:0]. Outputs: idx[N-1:0] and found.
  - It is instantiated once. Fixed mode drives start=M-1.
- The top level contains the FSM, the ptr register, the output registers and the elaboration check on M/N.

## Test plan
- **Reset:** with M=8, N=3, hold rst=1 for 2 cycles, then release. Expect out_valid=0, y=0 and grant=0, and the first RR grant for req=8'h03 is y=1.
- **Fixed priority:** mode=0, en=1, req=8'b0010_0110, out_ready=1. After 1 cycle expect out_valid=1, y=5 and grant=8'h20.
- **Backpressure:** hold out_ready=0 for 3 cycles while req changes to 8'h80. y stays 5 throughout. Raise out_ready=1; after the next edge expect y=7 with out_valid still 1 (back-to-back).
- **Round-robin fairness:** mode=1, req=8'hFF held, out_ready=1. Expect one grant per cycle with y = 7,6,5,4,3,2,1,0,7, and ptr wraps correctly.
- **Round-robin sparse:** mode=1, req=8'h81 held. Expect y alternating 7,0,7,0. Then set en=0; after the current handshake, out_valid=0 and y=0.
- **Reset during HOLD:** while out_valid=1 with out_ready=1, assert rst. The next cycle shows out_valid=0 and the grant is not re-issued. ptr is M-1, so RR with req=8'h03 grants y=1.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared definitions for the registered request encoder / round-robin arbiter.
package encoder_pkg;

    // Arbitration mode select values
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // IDLE: no grant outstanding; HOLD: grant presented and waiting for out_ready
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/encoder_rr_search.sv
// Combinational circular priority search: starting at index 'start' and
// moving downward with wrap at M, returns the first set request bit.
module encoder_rr_search
    import encoder_pkg::*;
#(
    parameter int M  = 8,
    parameter int N  = 3,
    parameter int PW = $clog2(M)
) (
    input  logic [M-1:0]  req,
    input  logic [PW-1:0] start,
    output logic [N-1:0]  idx,
    output logic          found
);

    // pos[k] is the requester examined at search step k; hit[k] says it is pending
    logic [PW-1:0] pos [M];
    logic [M-1:0]  hit;

    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_step
            // start - gi, wrapped at M (start is always < M, so one correction suffices)
            assign pos[gi] = (int'(start) >= gi) ? PW'(int'(start) - gi)
                                                 : PW'(int'(start) + M - gi);
            assign hit[gi] = req[pos[gi]];
        end
    endgenerate

    // Pick the earliest search step that hits; later (lower k) assignments win
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = M - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx   = N'(pos[k]);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder_rr_arbiter.sv
// Registered M-to-N request encoder with fixed-priority / round-robin
// selection and a valid/ready output handshake. All outputs are registered.
module encoder_rr_arbiter
    import encoder_pkg::*;
#(
    parameter int M = 8,
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         mode,
    input  logic [M-1:0] req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y,
    output logic [M-1:0] grant
);

    localparam int PW = $clog2(M);

    // Reject parameter sets the index output cannot represent
    generate
        if (M < 2 || (1 << N) < M) begin : g_param_check
            $error("encoder_rr_arbiter: need M >= 2 and 2**N >= M");
        end
    endgenerate

    state_t        state_reg;
    logic [PW-1:0] ptr_reg;
    logic [N-1:0]  y_reg;
    logic [M-1:0]  grant_reg;
    logic          valid_reg;

    logic          handshake;
    logic          arb_event;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] start;
    logic [N-1:0]  w_idx;
    logic          w_found;
    logic [M-1:0]  grant_next;

    // Consumer accepts the held grant this cycle
    assign handshake = valid_reg && out_ready;

    // The just-served requester drops to lowest priority; a back-to-back
    // re-arbitration in the same cycle must already see the rotated pointer
    assign ptr_next = handshake ? ((y_reg == '0) ? PW'(M - 1) : PW'(y_reg - 1'b1))
                                : ptr_reg;

    // Fixed priority is a circular search that always starts at the top index
    assign start = (mode == MODE_RR) ? ptr_next : PW'(M - 1);

    encoder_rr_search #(
        .M  (M),
        .N  (N),
        .PW (PW)
    ) u_search (
        .req   (req),
        .start (start),
        .idx   (w_idx),
        .found (w_found)
    );

    // w_found is equivalent to req != 0
    assign arb_event = en && w_found && ((state_reg == IDLE) || handshake);

    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_onehot
            assign grant_next[gi] = (w_idx == N'(gi));
        end
    endgenerate

    // Arbitration FSM with pointer and registered outputs; reset drops any pending grant
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= PW'(M - 1);
            y_reg     <= '0;
            grant_reg <= '0;
            valid_reg <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
            unique case (state_reg)
                IDLE: begin
                    if (arb_event) begin
                        state_reg <= HOLD;
                        y_reg     <= w_idx;
                        grant_reg <= grant_next;
                        valid_reg <= 1'b1;
                    end
                end
                HOLD: begin
                    if (arb_event) begin
                        y_reg     <= w_idx;
                        grant_reg <= grant_next;
                        valid_reg <= 1'b1;
                    end else if (handshake) begin
                        state_reg <= IDLE;
                        y_reg     <= '0;
                        grant_reg <= '0;
                        valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    y_reg     <= '0;
                    grant_reg <= '0;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = valid_reg;
    assign y         = y_reg;
    assign grant     = grant_reg;

endmodule

// File: tb/tb_encoder_rr_arbiter.sv
// Self-checking bench for encoder_rr_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_encoder_rr_arbiter;

    localparam int M = 8;
    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         mode;
    logic [M-1:0] req;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] y;
    logic [M-1:0] grant;

    int tests = 0;
    int fails = 0;

    // Reference model state: outstanding grant, its index and the RR pointer
    int m_valid;
    int m_y;
    int m_ptr;

    encoder_rr_arbiter #(
        .M (M),
        .N (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .req       (req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Winner by walking the priority order: RR from p downward with wrap, fixed from M-1
    function automatic int winner(input logic [M-1:0] r, input bit rr, input int p);
        int s;
        s = rr ? p : M - 1;
        for (int k = 0; k < M; k++) begin
            if (r[(s - k + M) % M]) return (s - k + M) % M;
        end
        return 0;
    endfunction

    // One clock transaction: drive inputs, advance the model, compare after the edge
    task automatic step(input bit r, input bit e, input bit md, input logic [M-1:0] rq,
                        input bit rd);
        int hs;
        int p;
        int nv;
        int ny;
        logic [M-1:0] eg;
        rst = r; en = e; mode = md; req = rq; out_ready = rd;
        if (r) begin
            nv = 0; ny = 0; p = M - 1;
        end else begin
            hs = (m_valid != 0 && rd) ? 1 : 0;
            p  = hs ? ((m_y == 0) ? M - 1 : m_y - 1) : m_ptr;
            nv = m_valid; ny = m_y;
            if (e && rq != '0 && (m_valid == 0 || hs != 0)) begin
                nv = 1; ny = winner(rq, md, p);
            end else if (hs != 0) begin
                nv = 0; ny = 0;
            end
        end
        @(posedge clk);
        #1;
        m_valid = nv; m_y = ny; m_ptr = p;
        eg = (m_valid != 0) ? (M'(1) << m_y) : '0;
        $display("[TB] t=%0t rst=%0b en=%0b mode=%0b req=%02h rdy=%0b -> valid=%0b y=%0d grant=%02h",
                 $time, r, e, md, rq, rd, out_valid, y, grant);
        chk("model_valid", 32'(out_valid), 32'(m_valid));
        chk("model_y", 32'(y), 32'(m_y));
        chk("model_grant", 32'(grant), 32'(eg));
    endtask

    initial begin
        logic [M-1:0] rq;
        int rr_seq [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        m_valid = 0; m_y = 0; m_ptr = M - 1;
        rst = 1'b1; en = 1'b0; mode = 1'b0; req = '0; out_ready = 1'b0;

        // Reset for two cycles, then idle
        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 1);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_y", 32'(y), 32'd0);
        chk("reset_grant", 32'(grant), 32'd0);
        step(0, 1, 1, 8'h03, 0);
        chk("reset_first_rr_y", 32'(y), 32'd1);
        step(0, 0, 1, 8'h03, 1);
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Fixed priority: highest index wins
        step(0, 1, 0, 8'b0010_0110, 1);
        chk("fixed_valid", 32'(out_valid), 32'd1);
        chk("fixed_y", 32'(y), 32'd5);
        chk("fixed_grant", 32'(grant), 32'h20);

        // Backpressure: grant frozen while out_ready=0
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 8'h80, 0);
            chk("bp_hold_y", 32'(y), 32'd5);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        step(0, 1, 0, 8'h80, 1);
        chk("bp_b2b_y", 32'(y), 32'd7);
        chk("bp_b2b_valid", 32'(out_valid), 32'd1);

        // Round-robin fairness from a fresh pointer
        step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 9; i++) begin
            step(0, 1, 1, 8'hFF, 1);
            chk("rr_full_y", 32'(y), 32'(rr_seq[i]));
        end

        // Round-robin with two sparse requesters
        step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 8'h81, 1);
            chk("rr_sparse_y", 32'(y), (i % 2 == 0) ? 32'd7 : 32'd0);
        end
        step(0, 0, 1, 8'h81, 1);
        chk("rr_sparse_off_valid", 32'(out_valid), 32'd0);
        chk("rr_sparse_off_y", 32'(y), 32'd0);

        // Reset during HOLD with a handshake pending
        step(0, 1, 0, 8'h40, 1);
        chk("rst_hold_pre_valid", 32'(out_valid), 32'd1);
        step(1, 1, 0, 8'h40, 1);
        chk("rst_hold_valid", 32'(out_valid), 32'd0);
        step(0, 0, 0, 8'h40, 1);
        chk("rst_hold_no_reissue", 32'(out_valid), 32'd0);
        step(0, 1, 1, 8'h03, 1);
        chk("rst_hold_rr_y", 32'(y), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rq = M'($urandom);
            if ($urandom_range(0, 5) == 0) rq = '0;
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), rq, $urandom_range(0, 2) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
